// File: rtl/mux_pkg.sv
// Shared constants for the registered 8-to-1 lane select.
// Lane count, select width and the default one-bit lane type.
package mux_pkg;

    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;
    localparam int LANE_W  = 1;

    typedef logic [LANE_W-1:0] lane_t;

endpackage : mux_pkg

// File: rtl/mux2.sv
// 2:1 lane mux, y = sel ? b : a.
// Purely combinational; no flow control.
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule : mux2

// File: rtl/max_8to1.sv
// Registered 8-to-1 lane select: three levels of mux2 feeding one output register.
// Latency one clock; no backpressure, a new selection is accepted every cycle.
module max_8to1
    import mux_pkg::*;
#(
    parameter int WIDTH = LANE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         s,
    input  logic [N_LANES*WIDTH-1:0] d,
    output logic [WIDTH-1:0]         o
);

    logic [3:0][WIDTH-1:0] lvl0;
    logic [1:0][WIDTH-1:0] lvl1;
    logic [WIDTH-1:0]      sel_lane_d;
    logic [WIDTH-1:0]      o_q;

    // Level 0 pairs adjacent lanes (0,1),(2,3),(4,5),(6,7) on s[0].
    for (genvar i = 0; i < 4; i++) begin : g_lvl0
        mux2 #(.WIDTH(WIDTH)) u_mux (
            .a   (d[(2*i)*WIDTH +: WIDTH]),
            .b   (d[(2*i+1)*WIDTH +: WIDTH]),
            .sel (s[0]),
            .y   (lvl0[i])
        );
    end

    for (genvar j = 0; j < 2; j++) begin : g_lvl1
        mux2 #(.WIDTH(WIDTH)) u_mux (
            .a   (lvl0[2*j]),
            .b   (lvl0[2*j+1]),
            .sel (s[1]),
            .y   (lvl1[j])
        );
    end

    mux2 #(.WIDTH(WIDTH)) u_mux_lvl2 (
        .a   (lvl1[0]),
        .b   (lvl1[1]),
        .sel (s[2]),
        .y   (sel_lane_d)
    );

    // Register makes o glitch-free; it moves only on an edge or reset assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else begin
            o_q <= sel_lane_d;
        end
    end

    assign o = o_q;

endmodule : max_8to1

// File: tb/tb_max_8to1.sv
// Bench for max_8to1: one-bit-lane and four-bit-lane instances checked
// against a shift-and-mask reference of the lane-select rule.
module tb_max_8to1;

    logic        clk;
    logic        rst_n;
    logic [2:0]  s1;
    logic [7:0]  d1;
    logic [0:0]  o1;
    logic [2:0]  s4;
    logic [31:0] d4;
    logic [3:0]  o4;

    int checks;
    int failures;

    max_8to1 #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s1),
        .d     (d1),
        .o     (o1)
    );

    max_8to1 #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s4),
        .d     (d4),
        .o     (o4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:0] ref1(input logic [7:0] dd, input logic [2:0] ss);
        logic [7:0] t;
        t = dd >> ss;
        return t[0];
    endfunction

    function automatic logic [3:0] ref4(input logic [31:0] dd, input logic [2:0] ss);
        logic [31:0] t;
        t = dd >> (32'(ss) * 4);
        return t[3:0];
    endfunction

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        d1 = 8'hFF; s1 = 3'd7;
        d4 = 32'hFFFF_FFFF; s4 = 3'd7;
        after_edge();
        checks++;
        if (o1 !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_load o=%b expected=1", o1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o1 !== 1'b0 || o4 !== 4'h0) begin
            failures++;
            $display("FAIL reset_async o1=%b o4=%h expected=0", o1, o4);
        end
        for (int i = 0; i < 4; i++) begin
            after_edge();
            checks++;
            if (o1 !== 1'b0 || o4 !== 4'h0) begin
                failures++;
                $display("FAIL reset_hold edge=%0d o1=%b o4=%h expected=0", i, o1, o4);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [0:0] exp;
        @(negedge clk);
        d1 = 8'hE9;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s1 = 3'(k);
            exp = ref1(d1, s1);
            for (int c = 0; c < 10; c++) begin
                after_edge();
                if (c == 0 || c == 9) begin
                    checks++;
                    if (o1 !== exp) begin
                        failures++;
                        $display("FAIL sweep s=%0d cyc=%0d o=%b expected=%b", k, c, o1, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_walking_one();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            d1 = 8'(1 << k);
            s1 = 3'(k);
            after_edge();
            checks++;
            if (o1 !== ref1(d1, s1) || o1 !== 1'b1) begin
                failures++;
                $display("FAIL walk_hit k=%0d o=%b expected=1", k, o1);
            end
            @(negedge clk);
            s1 = 3'((k + 1) % 8);
            after_edge();
            checks++;
            if (o1 !== ref1(d1, s1) || o1 !== 1'b0) begin
                failures++;
                $display("FAIL walk_miss k=%0d o=%b expected=0", k, o1);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        d1 = 8'h80; s1 = 3'd0;
        after_edge();
        checks++;
        if (o1 !== 1'b0) begin
            failures++;
            $display("FAIL latency_base o=%b expected=0", o1);
        end
        @(negedge clk);
        s1 = 3'd7;
        #1;
        checks++;
        if (o1 !== 1'b0) begin
            failures++;
            $display("FAIL latency_early o=%b expected=0", o1);
        end
        after_edge();
        checks++;
        if (o1 !== 1'b1) begin
            failures++;
            $display("FAIL latency_edge o=%b expected=1", o1);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        d1 = 8'hFF; s1 = 3'd3;
        after_edge();
        checks++;
        if (o1 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre o=%b expected=1", o1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o1 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async o=%b expected=0", o1);
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (o1 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release o=%b expected=0", o1);
        end
        after_edge();
        checks++;
        if (o1 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_recover o=%b expected=1", o1);
        end
    endtask

    task automatic test_width();
        @(negedge clk);
        d4 = 32'h7654_3210;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s4 = 3'(k);
            #1;
            if (k > 0) begin
                checks++;
                if (o4 !== 4'(k - 1)) begin
                    failures++;
                    $display("FAIL width_hold s=%0d o=%h expected=%h", k, o4, 4'(k - 1));
                end
            end
            after_edge();
            checks++;
            if (o4 !== ref4(d4, s4) || o4 !== 4'(k)) begin
                failures++;
                $display("FAIL width s=%0d o=%h expected=%h", k, o4, 4'(k));
            end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [0:0] e1;
        logic [3:0] e4;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            d1 = 8'($urandom);
            s1 = 3'($urandom_range(0, 7));
            d4 = $urandom;
            s4 = 3'($urandom_range(0, 7));
            e1 = ref1(d1, s1);
            e4 = ref4(d4, s4);
            after_edge();
            checks++;
            if (o1 !== e1 || o4 !== e4) begin
                failures++;
                $display("FAIL random i=%0d o1=%b exp1=%b o4=%h exp4=%h", i, o1, e1, o4, e4);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        s1 = 3'd0; d1 = 8'h00;
        s4 = 3'd0; d4 = 32'h0;
        test_reset();
        test_sweep();
        test_walking_one();
        test_latency();
        test_mid_reset();
        test_width();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_max_8to1
